// File: rtl/matrix_pg_multi_pkg.sv
// Shared types and constants for the cascaded 8x8 LED matrix pattern generator.
package matrix_pkg;

    localparam int ROWS = 8;
    localparam logic [3:0] DIGIT_BASE = 4'h1;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        PACK  = 2'd1,
        DELAY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SCROLL_L = 2'd0,
        SCROLL_R = 2'd1,
        BOUNCE   = 2'd2,
        BAR      = 2'd3
    } mode_t;

    // Digit-register address of a row in the driver device.
    function automatic logic [3:0] row_addr(input logic [2:0] row);
        return DIGIT_BASE + {1'b0, row};
    endfunction

endpackage

// File: rtl/matrix_pg_multi_if.sv
// Control and frame-data bundle between the frame consumer and the pattern generator.
interface matrix_pg_multi_if #(
    parameter int N_DEV   = 4,
    parameter int DELAY_W = 24
);
    import matrix_pkg::*;

    logic                               send_done;
    logic [1:0]                         mode;
    logic                               pause;
    logic [7:0]                         row_mask;
    logic [DELAY_W-1:0]                 frame_delay;
    logic                               en;
    logic                               busy;
    logic [ROWS-1:0][16*N_DEV-1:0]      data;

    modport master (
        output send_done, mode, pause, row_mask, frame_delay,
        input  en, busy, data
    );

    modport slave (
        input  send_done, mode, pause, row_mask, frame_delay,
        output en, busy, data
    );

endinterface

// File: rtl/matrix_pg_multi_pattern_step.sv
// Animation state: holds the lit pattern and advances it one step per advance pulse.
module matrix_pattern_step
    import matrix_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_9m,
    input  logic         rst_n,
    input  logic         advance_i,
    input  logic [1:0]   mode_i,
    input  logic         pause_i,
    output logic [W-1:0] pat_o
);
    localparam int POS_W = $clog2(W);

    logic [W-1:0]     pat_q, pat_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    mode_t            mode_q, mode_d;
    logic [W-1:0]     therm_s;

    // Next animation state; a mode change reloads the initial pattern instead of stepping.
    always_comb begin
        pat_d    = pat_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        mode_d   = mode_q;
        if (advance_i && !pause_i) begin
            if (mode_t'(mode_i) != mode_q) begin
                mode_d = mode_t'(mode_i);
                case (mode_t'(mode_i))
                    SCROLL_L: pat_d = {{(W-1){1'b0}}, 1'b1};
                    SCROLL_R: pat_d = {1'b1, {(W-1){1'b0}}};
                    BOUNCE: begin
                        pat_d    = {{(W-1){1'b0}}, 1'b1};
                        dir_up_d = 1'b1;
                    end
                    BAR:      pos_d = {POS_W{1'b0}};
                    default:  pat_d = pat_q;
                endcase
            end else begin
                case (mode_q)
                    SCROLL_L: pat_d = {pat_q[W-2:0], pat_q[W-1]};
                    SCROLL_R: pat_d = {pat_q[0], pat_q[W-1:1]};
                    BOUNCE: begin
                        // Turn around at the ends so the end bits are shown only once per pass.
                        if (dir_up_q) begin
                            if (pat_q[W-1]) begin
                                pat_d    = pat_q >> 1;
                                dir_up_d = 1'b0;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (pat_q[0]) begin
                                pat_d    = pat_q << 1;
                                dir_up_d = 1'b1;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                    BAR: begin
                        if (pos_q == POS_W'(W-1)) begin
                            pos_d = {POS_W{1'b0}};
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end
                    default: pat_d = pat_q;
                endcase
            end
        end else begin
            pat_d = pat_q;
        end
    end

    // Animation state registers.
    always_ff @(posedge clk_9m or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= {{(W-1){1'b0}}, 1'b1};
            pos_q    <= {POS_W{1'b0}};
            dir_up_q <= 1'b1;
            mode_q   <= SCROLL_L;
        end else begin
            pat_q    <= pat_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            mode_q   <= mode_d;
        end
    end

    // Bar display: pos+1 ones in the low bits.
    always_comb begin
        therm_s = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            therm_s[i] = (POS_W'(i) <= pos_q);
        end
    end

    assign pat_o = (mode_q == BAR) ? therm_s : pat_q;

endmodule

// File: rtl/matrix_pg_multi.sv
// Frame builder for a chain of 8x8 matrix drivers: packs one word per row, waits
// the frame delay, then pulses en; one animation step per send_done rising edge.
module matrix_pg_multi
    import matrix_pkg::*;
#(
    parameter int N_DEV   = 4,
    parameter int DELAY_W = 24
) (
    input  logic                clk_9m,
    input  logic                rst_n,
    matrix_pg_multi_if.slave    bus
);
    localparam int W      = 8 * N_DEV;
    localparam int WORD_W = 16 * N_DEV;

    state_t                         state_q, state_d;
    logic [2:0]                     row_q, row_d;
    logic [DELAY_W-1:0]             cnt_q, cnt_d;
    logic                           en_q, en_d;
    logic                           send_done_q;
    logic [ROWS-1:0][WORD_W-1:0]    data_q;
    logic [WORD_W-1:0]              word_s;
    logic [W-1:0]                   pat_s;
    logic                           rise_s;
    logic                           advance_s;

    assign rise_s = bus.send_done & ~send_done_q;

    matrix_pattern_step #(.W(W)) u_step (
        .clk_9m    (clk_9m),
        .rst_n     (rst_n),
        .advance_i (advance_s),
        .mode_i    (bus.mode),
        .pause_i   (bus.pause),
        .pat_o     (pat_s)
    );

    // Frame FSM next state; edges outside WAIT are dropped, not queued.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        en_d      = 1'b0;
        advance_s = 1'b0;
        case (state_q)
            WAIT: begin
                if (rise_s) begin
                    advance_s = 1'b1;
                    state_d   = PACK;
                    row_d     = 3'd0;
                end else begin
                    state_d = WAIT;
                end
            end
            PACK: begin
                row_d = row_q + 3'd1;
                if (row_q == 3'd7) begin
                    state_d = DELAY;
                    cnt_d   = {DELAY_W{1'b0}};
                end else begin
                    state_d = PACK;
                end
            end
            DELAY: begin
                if (cnt_q == bus.frame_delay) begin
                    state_d = WAIT;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + DELAY_W'(1);
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // FSM, counters, en and edge-detect history.
    always_ff @(posedge clk_9m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PACK;
            row_q       <= 3'd0;
            cnt_q       <= {DELAY_W{1'b0}};
            en_q        <= 1'b0;
            send_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            send_done_q <= bus.send_done;
        end
    end

    // Current row word: {0, digit address, gated byte} per device, device 0 at the LSB.
    always_comb begin
        word_s = {WORD_W{1'b0}};
        for (int d = 0; d < N_DEV; d++) begin
            word_s[16*d +: 16] = {4'h0, row_addr(row_q),
                                  bus.row_mask[row_q] ? pat_s[8*d +: 8] : 8'h00};
        end
    end

    // Row storage, written only while packing so the frame is stable otherwise.
    always_ff @(posedge clk_9m or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {(ROWS*WORD_W){1'b0}};
        end else if (state_q == PACK) begin
            data_q[row_q] <= word_s;
        end else begin
            data_q <= data_q;
        end
    end

    assign bus.en   = en_q;
    assign bus.busy = (state_q != WAIT);
    assign bus.data = data_q;

endmodule

// File: tb/tb_matrix_pg_multi.sv
// Directed self-checking bench for matrix_pg_multi with N_DEV=4, frame_delay=5.
module tb_matrix_pg_multi;

    logic clk_9m = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_9m = ~clk_9m;

    matrix_pg_multi_if #(.N_DEV(4), .DELAY_W(24)) bus ();

    matrix_pg_multi #(.N_DEV(4), .DELAY_W(24)) dut (
        .clk_9m (clk_9m),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input int r, input logic [31:0] p, input logic [7:0] m);
        logic [63:0] w;
        logic [7:0]  b;
        w = 64'h0;
        for (int d = 0; d < 4; d++) begin
            b = m[r] ? p[8*d +: 8] : 8'h00;
            w[16*d +: 16] = {4'h0, 4'(r + 1), b};
        end
        return w;
    endfunction

    task automatic check_frame(input string tag, input logic [31:0] p, input logic [7:0] m);
        for (int r = 0; r < 8; r++) begin
            check(tag, bus.data[r], exp_word(r, p, m));
        end
    endtask

    // Counts edges until en is seen; n is the latency in edges.
    task automatic wait_en(input bit inject, output int n);
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk_9m);
            n++;
            #1;
            if (inject && n == 3) bus.send_done = 1'b1;
            if (inject && n == 4) bus.send_done = 1'b0;
            if (bus.en === 1'b1) got = 1'b1;
        end
    endtask

    task automatic do_step(input string tag, input logic [31:0] p, input logic [7:0] m,
                           input int exp_n, input bit inject);
        int n;
        @(negedge clk_9m);
        bus.send_done = 1'b1;
        @(posedge clk_9m);
        #1;
        bus.send_done = 1'b0;
        wait_en(inject, n);
        check({tag, "_lat"}, 64'(n), 64'(exp_n));
        check({tag, "_busy"}, {63'h0, bus.busy}, 64'h0);
        check_frame({tag, "_frame"}, p, m);
        @(posedge clk_9m);
        #1;
        check({tag, "_enlow"}, {63'h0, bus.en}, 64'h0);
    endtask

    initial begin
        int          n;
        int          p;
        int          extra;
        logic [31:0] pat;

        rst_n           = 1'b0;
        bus.send_done   = 1'b0;
        bus.mode        = 2'd0;
        bus.pause       = 1'b0;
        bus.row_mask    = 8'hFF;
        bus.frame_delay = 24'd5;

        repeat (3) @(posedge clk_9m);
        #1;
        check("rst_en", {63'h0, bus.en}, 64'h0);
        check("rst_busy", {63'h0, bus.busy}, 64'h1);
        check("rst_data0", bus.data[0], 64'h0);

        // First frame comes up without send_done.
        @(negedge clk_9m);
        rst_n = 1'b1;
        wait_en(1'b0, n);
        check("first_lat", 64'(n), 64'd14);
        check("first_busy", {63'h0, bus.busy}, 64'h0);
        check("first_row0", bus.data[0], 64'h0100_0100_0100_0101);
        check("first_row7", bus.data[7], 64'h0800_0800_0800_0801);
        check_frame("first_frame", 32'h1, 8'hFF);
        @(posedge clk_9m);
        #1;
        check("first_enlow", {63'h0, bus.en}, 64'h0);

        // SCROLL_L: 33 steps, lit bit walks up and wraps.
        pat = 32'h1;
        for (int i = 1; i <= 33; i++) begin
            pat = {pat[30:0], pat[31]};
            do_step("scroll_l", pat, 8'hFF, 14, 1'b0);
        end
        check("scroll_l_final", bus.data[0], 64'h0100_0100_0100_0102);

        // BOUNCE: switch loads bit 0, then positions 1..31,30..0,1.
        bus.mode = 2'd2;
        do_step("bounce_init", 32'h1, 8'hFF, 14, 1'b0);
        for (int k = 1; k <= 63; k++) begin
            p = (k <= 31) ? k : ((k <= 62) ? 62 - k : k - 62);
            pat = 32'h1 << p;
            do_step("bounce", pat, 8'hFF, 14, 1'b0);
        end

        // BAR: switch gives pos 0, then thermometer growing and wrapping.
        bus.mode = 2'd3;
        do_step("bar_init", 32'h1, 8'hFF, 14, 1'b0);
        do_step("bar1", 32'h3, 8'hFF, 14, 1'b0);
        do_step("bar2", 32'h7, 8'hFF, 14, 1'b0);
        do_step("bar3", 32'hF, 8'hFF, 14, 1'b0);
        check("bar3_row0", bus.data[0], 64'h0100_0100_0100_010F);
        for (int i = 4; i <= 31; i++) begin
            pat = (i == 31) ? 32'hFFFF_FFFF : ((32'h1 << (i + 1)) - 32'h1);
            do_step("bar", pat, 8'hFF, 14, 1'b0);
        end
        check("bar31_row0", bus.data[0], 64'h01FF_01FF_01FF_01FF);
        do_step("bar_wrap", 32'h1, 8'hFF, 14, 1'b0);
        check("bar_wrap_row0", bus.data[0], 64'h0100_0100_0100_0101);

        // Row gating on a SCROLL_L frame.
        bus.mode     = 2'd0;
        bus.row_mask = 8'h81;
        do_step("mask81", 32'h1, 8'h81, 14, 1'b0);
        check("mask81_row1", bus.data[1], 64'h0200_0200_0200_0200);
        check("mask81_row7", bus.data[7], 64'h0800_0800_0800_0801);

        // Pause: pattern frozen, frames still emitted, mask change applied.
        bus.row_mask = 8'hFF;
        bus.pause    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_step("pause", 32'h1, 8'hFF, 14, 1'b0);
        end
        bus.pause = 1'b0;

        // send_done pulse during PACK must be dropped.
        do_step("inject", 32'h2, 8'hFF, 14, 1'b1);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_9m);
            #1;
            if (bus.en === 1'b1) extra++;
        end
        check("inject_no_en", 64'(extra), 64'd0);
        check("inject_idle", {63'h0, bus.busy}, 64'h0);
        do_step("after_inject", 32'h4, 8'hFF, 14, 1'b0);

        // Zero frame delay still costs one DELAY cycle.
        bus.frame_delay = 24'd0;
        do_step("fd0", 32'h8, 8'hFF, 9, 1'b0);
        bus.frame_delay = 24'd5;

        // Switch to SCROLL_R loads bit 31.
        bus.mode = 2'd1;
        do_step("scroll_r", 32'h8000_0000, 8'hFF, 14, 1'b0);
        check("scroll_r_row0", bus.data[0], 64'h0180_0100_0100_0100);

        // Reset in the middle of DELAY.
        @(negedge clk_9m);
        bus.send_done = 1'b1;
        @(posedge clk_9m);
        #1;
        bus.send_done = 1'b0;
        repeat (11) @(posedge clk_9m);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_en", {63'h0, bus.en}, 64'h0);
        check("midrst_row0", bus.data[0], 64'h0);
        check("midrst_row7", bus.data[7], 64'h0);
        check("midrst_busy", {63'h0, bus.busy}, 64'h1);
        bus.mode = 2'd0;
        @(negedge clk_9m);
        rst_n = 1'b1;
        wait_en(1'b0, n);
        check("rerst_lat", 64'(n), 64'd14);
        check_frame("rerst_frame", 32'h1, 8'hFF);
        do_step("rerst_step", 32'h2, 8'hFF, 14, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
